// File: rtl/pipe_controller_pkg.sv
// Shared Y86-64 encodings for the pipeline controller: icodes, register ids,
// status codes and controller state encodings.
package pipe_controller_pkg;

  localparam int unsigned ICODE_W = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned STAT_W  = 4;
  localparam int unsigned STATE_W = 2;

  // Instruction codes
  localparam logic [ICODE_W-1:0] IHALT   = 4'h0;
  localparam logic [ICODE_W-1:0] INOP    = 4'h1;
  localparam logic [ICODE_W-1:0] IRRMOVQ = 4'h2;
  localparam logic [ICODE_W-1:0] IIRMOVQ = 4'h3;
  localparam logic [ICODE_W-1:0] IRMMOVQ = 4'h4;
  localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
  localparam logic [ICODE_W-1:0] IOPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
  localparam logic [ICODE_W-1:0] ICALL   = 4'h8;
  localparam logic [ICODE_W-1:0] IRET    = 4'h9;
  localparam logic [ICODE_W-1:0] IPUSHQ  = 4'hA;
  localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

  // Register id meaning "no register"
  localparam logic [REG_W-1:0] RNONE = 4'hF;

  // Status codes
  localparam logic [STAT_W-1:0] SAOK = 4'h1;
  localparam logic [STAT_W-1:0] SADR = 4'h2;
  localparam logic [STAT_W-1:0] SINS = 4'h3;
  localparam logic [STAT_W-1:0] SHLT = 4'h4;

  // Controller states
  localparam logic [STATE_W-1:0] PC_RUN   = 2'd0;
  localparam logic [STATE_W-1:0] PC_DMISS = 2'd1;
  localparam logic [STATE_W-1:0] PC_DRAIN = 2'd2;
  localparam logic [STATE_W-1:0] PC_DONE  = 2'd3;

endpackage

// File: rtl/pipe_perf_counters.sv
// Saturating performance counters for the pipeline controller.
// Only instantiated when PIPE_PERF_EN is defined.
module pipe_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             active_i,
  input  logic             retire_i,
  input  logic             stall_i,
  input  logic             mp_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retired_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Counters advance only while the pipeline is live and stop at all-ones
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cycle_cnt_o      <= '0;
      retired_cnt_o    <= '0;
      stall_cnt_o      <= '0;
      mispredict_cnt_o <= '0;
    end else if (active_i) begin
      if (cycle_cnt_o != CNT_MAX)
        cycle_cnt_o <= cycle_cnt_o + CNT_ONE;
      if (retire_i && (retired_cnt_o != CNT_MAX))
        retired_cnt_o <= retired_cnt_o + CNT_ONE;
      if (stall_i && (stall_cnt_o != CNT_MAX))
        stall_cnt_o <= stall_cnt_o + CNT_ONE;
      if (mp_i && (mispredict_cnt_o != CNT_MAX))
        mispredict_cnt_o <= mispredict_cnt_o + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipeline-control FSM for the 5-stage Y86-64 core: per-stage stall/bubble
// from load-use, ret, mispredict and cache-miss hazards, plus halt/exception
// drain sequencing and done_o.
// Optional feature macro: PIPE_PERF_EN adds saturating performance counters.
module pipe_controller
  import pipe_controller_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [ICODE_W-1:0] D_icode_i,
  input  logic [REG_W-1:0]   d_srcA_i,
  input  logic [REG_W-1:0]   d_srcB_i,
  input  logic [ICODE_W-1:0] E_icode_i,
  input  logic [REG_W-1:0]   E_dstM_i,
  input  logic               e_mispredict_i,
  input  logic [ICODE_W-1:0] M_icode_i,
  input  logic [STAT_W-1:0]  m_stat_i,
  input  logic [STAT_W-1:0]  W_stat_i,
  input  logic               imem_busy_i,
  input  logic               dmem_busy_i,
  output logic               F_stall_o,
  output logic               D_stall_o,
  output logic               W_stall_o,
  output logic               D_bubble_o,
  output logic               E_bubble_o,
  output logic               M_bubble_o,
`ifdef PIPE_PERF_EN
  output logic [CNT_W-1:0]   cycle_cnt_o,
  output logic [CNT_W-1:0]   retired_cnt_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   mispredict_cnt_o,
`endif
  output logic               done_o
);

  localparam int unsigned DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LOAD = DCNT_W'(DRAIN_CYCLES - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic               done_d;

  logic lu, ret, mp, w_exc, mexc;

  // Hazard detection
  always_comb begin
    lu    = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) &&
            (E_dstM_i != RNONE) &&
            ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    ret   = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
    mp    = e_mispredict_i;
    w_exc = (W_stat_i != SAOK);
    mexc  = (m_stat_i != SAOK) || w_exc;
  end

  // State, drain counter and done flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= PC_RUN;
      dcnt_q  <= '0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      done_o  <= done_d;
    end
  end

  // Next-state and stall/bubble decode
  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    done_d     = done_o;
    F_stall_o  = 1'b0;
    D_stall_o  = 1'b0;
    W_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_bubble_o = 1'b0;
    M_bubble_o = 1'b0;

    case (state_q)
      PC_RUN, PC_DMISS: begin
        // A miss freezes F/D/W; E and M must hold, so no bubbles are injected
        if ((state_q == PC_DMISS) || (dmem_busy_i && !w_exc)) begin
          F_stall_o = 1'b1;
          D_stall_o = 1'b1;
          W_stall_o = 1'b1;
        end else begin
          F_stall_o  = lu | ret | imem_busy_i;
          D_stall_o  = lu;
          D_bubble_o = mp | (!lu & (ret | imem_busy_i));
          E_bubble_o = mp | lu;
          M_bubble_o = mexc;
          W_stall_o  = w_exc;
        end
        // An exception reaching W outranks an outstanding D-cache miss
        if (w_exc) begin
          state_d = PC_DRAIN;
          dcnt_d  = DCNT_LOAD;
        end else if (dmem_busy_i) begin
          state_d = PC_DMISS;
        end else begin
          state_d = PC_RUN;
        end
      end
      PC_DRAIN: begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        W_stall_o  = 1'b1;
        M_bubble_o = 1'b1;
        if (dcnt_q == '0) begin
          state_d = PC_DONE;
          done_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q - DCNT_W'(1);
        end
      end
      default: begin
        F_stall_o = 1'b1;
        D_stall_o = 1'b1;
        W_stall_o = 1'b1;
      end
    endcase
  end

`ifdef PIPE_PERF_EN
  logic perf_active;
  logic perf_retire;

  // Count only while the pipeline is live; a held W does not retire
  always_comb begin
    perf_active = (state_q == PC_RUN) || (state_q == PC_DMISS);
    perf_retire = (W_stat_i == SAOK) && !W_stall_o;
  end

  pipe_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .active_i         (perf_active),
    .retire_i         (perf_retire),
    .stall_i          (F_stall_o),
    .mp_i             (mp),
    .cycle_cnt_o      (cycle_cnt_o),
    .retired_cnt_o    (retired_cnt_o),
    .stall_cnt_o      (stall_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller (DRAIN_CYCLES=2).
// Observed vector order: {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, done}.
module tb_pipe_controller;
  import pipe_controller_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [3:0] D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i;
  logic [3:0] M_icode_i, m_stat_i, W_stat_i;
  logic       e_mispredict_i, imem_busy_i, dmem_busy_i;
  logic       F_stall_o, D_stall_o, W_stall_o;
  logic       D_bubble_o, E_bubble_o, M_bubble_o, done_o;
`ifdef PIPE_PERF_EN
  logic [31:0] cycle_cnt_o, retired_cnt_o, stall_cnt_o, mispredict_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  logic [6:0] outs;
  assign outs = {F_stall_o, D_stall_o, W_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, done_o};

  always #5 clk_i = ~clk_i;

  pipe_controller #(.DRAIN_CYCLES(2), .CNT_W(32)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .D_icode_i        (D_icode_i),
    .d_srcA_i         (d_srcA_i),
    .d_srcB_i         (d_srcB_i),
    .E_icode_i        (E_icode_i),
    .E_dstM_i         (E_dstM_i),
    .e_mispredict_i   (e_mispredict_i),
    .M_icode_i        (M_icode_i),
    .m_stat_i         (m_stat_i),
    .W_stat_i         (W_stat_i),
    .imem_busy_i      (imem_busy_i),
    .dmem_busy_i      (dmem_busy_i),
    .F_stall_o        (F_stall_o),
    .D_stall_o        (D_stall_o),
    .W_stall_o        (W_stall_o),
    .D_bubble_o       (D_bubble_o),
    .E_bubble_o       (E_bubble_o),
    .M_bubble_o       (M_bubble_o),
`ifdef PIPE_PERF_EN
    .cycle_cnt_o      (cycle_cnt_o),
    .retired_cnt_o    (retired_cnt_o),
    .stall_cnt_o      (stall_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o),
`endif
    .done_o           (done_o)
  );

  task automatic idle();
    D_icode_i = INOP; d_srcA_i = RNONE; d_srcB_i = RNONE;
    E_icode_i = INOP; E_dstM_i = RNONE; e_mispredict_i = 1'b0;
    M_icode_i = INOP; m_stat_i = SAOK; W_stat_i = SAOK;
    imem_busy_i = 1'b0; dmem_busy_i = 1'b0;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    #1;
    total++;
    assert (outs === exp) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", tag, outs, exp);
    end
  endtask

  initial begin
    idle();
    rst_n_i = 1'b0;
    #3;
    chk("reset", 7'b000_000_0);
    #4 rst_n_i = 1'b1;

    tick(); idle(); chk("idle_run", 7'b000_000_0);

    // Load-use via srcA
    tick(); E_icode_i = IMRMOVQ; E_dstM_i = 4'd3; d_srcA_i = 4'd3;
    chk("lu_srcA", 7'b110_010_0);
    tick(); idle(); chk("lu_gone", 7'b000_000_0);

    // Load-use via srcB with POPQ
    tick(); E_icode_i = IPOPQ; E_dstM_i = 4'd5; d_srcB_i = 4'd5;
    chk("lu_popq_srcB", 7'b110_010_0);

    // RNONE on both sides is not a hazard
    tick(); idle(); E_icode_i = IMRMOVQ;
    chk("lu_rnone", 7'b000_000_0);

    // Load-use together with I-cache miss: lu wins for D
    tick(); idle(); E_icode_i = IMRMOVQ; E_dstM_i = 4'd2; d_srcA_i = 4'd2; imem_busy_i = 1'b1;
    chk("lu_imiss", 7'b110_010_0);

    tick(); idle(); imem_busy_i = 1'b1;
    chk("imiss", 7'b100_100_0);

    // ret walking through D, E, M
    tick(); idle(); D_icode_i = IRET; chk("ret_D", 7'b100_100_0);
    tick(); idle(); E_icode_i = IRET; chk("ret_E", 7'b100_100_0);
    tick(); idle(); M_icode_i = IRET; chk("ret_M", 7'b100_100_0);
    tick(); idle(); chk("ret_gone", 7'b000_000_0);

    tick(); e_mispredict_i = 1'b1; chk("mispredict", 7'b000_110_0);

    tick(); idle(); m_stat_i = SADR; chk("m_exc", 7'b000_001_0);

    // D-cache miss for 4 cycles; mispredict/m exception must not bubble meanwhile
    tick(); idle(); dmem_busy_i = 1'b1; chk("dmiss_c0", 7'b111_000_0);
    tick(); chk("dmiss_c1", 7'b111_000_0);
    tick(); e_mispredict_i = 1'b1; m_stat_i = SADR; chk("dmiss_c2_hold", 7'b111_000_0);
    tick(); e_mispredict_i = 1'b0; m_stat_i = SAOK; chk("dmiss_c3", 7'b111_000_0);
    tick(); dmem_busy_i = 1'b0; chk("dmiss_last", 7'b111_000_0);
    tick(); chk("dmiss_back_run", 7'b000_000_0);

    // Halt arriving during a miss -> drain -> done after two edges
    tick(); dmem_busy_i = 1'b1; chk("dmiss2_c0", 7'b111_000_0);
    tick(); W_stat_i = SHLT; chk("dmiss2_halt", 7'b111_000_0);
    tick(); idle(); chk("drain_1", 7'b111_001_0);
    tick(); chk("drain_2", 7'b111_001_0);
    tick(); chk("done_rise", 7'b111_000_1);
    tick(); chk("done_hold", 7'b111_000_1);
    tick(); chk("done_hold2", 7'b111_000_1);

    // Reset from DONE
    rst_n_i = 1'b0; chk("rst_from_done", 7'b000_000_0);
    #2 rst_n_i = 1'b1;
    tick(); chk("run_after_done_rst", 7'b000_000_0);

    // Exception in W outranks a D-cache miss
    tick(); W_stat_i = SINS; dmem_busy_i = 1'b1; chk("wexc_over_dmiss", 7'b001_001_0);
    tick(); idle(); chk("drain_not_dmiss", 7'b111_001_0);

    // Reset mid-drain
    rst_n_i = 1'b0; chk("rst_mid_drain", 7'b000_000_0);
`ifdef PIPE_PERF_EN
    total++;
    assert ({cycle_cnt_o, retired_cnt_o, stall_cnt_o, mispredict_cnt_o} === 128'd0) else begin
      bad++;
      $error("FAIL perf_reset obs=%h exp=0",
             {cycle_cnt_o, retired_cnt_o, stall_cnt_o, mispredict_cnt_o});
    end
`endif
    #2 rst_n_i = 1'b1;
    tick(); chk("run_after_drain_rst", 7'b000_000_0);
    tick(); chk("run_stays", 7'b000_000_0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
